apb_wait_slave: RTL
===================

// Module: apb_wait_slave
// PURPOSE
//  APB completer (slave) with a register-file backing store and a programmable number of wait states.
//  Sits downstream of the APB master on the shared PADDR/PWDATA/PWRITE/PENABLE bus, behind one PSELECT line.
//  Adds wait-state and error-response behaviour the zero-wait slaves lack, so the master's PREADY/PSLVERR
//  handling is exercised.
// PARAMETERS
//  ADDR_W      7   APB address width; PADDR[ADDR_W-2:0] is the word index, MSB is the slave-select bit
//  DATA_W      8   PWDATA/PRDATA width
//  MEM_DEPTH   48  implemented words; index >= MEM_DEPTH is an error location
//  WAIT_CYCLES 2   access-phase cycles with PREADY low before completion (0 = zero-wait)
// PORTS
//  PCLK      in   1       clock, all state on rising edge
//  PRESET    in   1       synchronous, active-high reset
//  PSELECT   in   1       slave select from master
//  PENABLE   in   1       access-phase strobe
//  PWRITE    in   1       1 = write, 0 = read
//  PADDR     in   ADDR_W  address
//  PWDATA    in   DATA_W  write data
//  PRDATA    out  DATA_W  read data, valid only when PREADY=1 on a read
//  PREADY    out  1       transfer completes this cycle
//  PSLVERR   out  1       error response, valid only when PREADY=1
//  xfer_cnt  out  8       completed transfers (ok + error), wraps 255->0
// BEHAVIOUR
//  Reset (PRESET=1 at edge): state=IDLE, wcnt=0, xfer_cnt=0, all MEM_DEPTH words cleared to 0.
//   PRDATA=0, PREADY=0, PSLVERR=0 in the following cycle.
//  Outputs are decoded from registered state only; no comb path from bus inputs to PREADY/PSLVERR.
//  FSM: IDLE, SETUP, ACCESS.
//   IDLE  : PSELECT & !PENABLE -> SETUP (latch PADDR, PWRITE, PWDATA). PENABLE without setup is ignored.
//   SETUP : PSELECT & PENABLE -> ACCESS, wcnt=0. !PSELECT -> IDLE (aborted). PSELECT & !PENABLE -> SETUP,
//           re-latching the bus.
//   ACCESS: PREADY = (wcnt==WAIT_CYCLES). While PREADY=0 and PSELECT&PENABLE, wcnt++.
//           Completion edge (PREADY=1): commit the write if no error, xfer_cnt++.
//           Next state is SETUP if PSELECT & !PENABLE (back-to-back, bus re-latched), else IDLE.
//           !PSELECT or !PENABLE before PREADY -> IDLE: no write, no count.
//  Latency: setup cycle + (WAIT_CYCLES+1) access cycles. Minimum 2 cycles per transfer.
//  Error: idx = PADDR[ADDR_W-2:0]; PSLVERR=1 with PREADY iff idx >= MEM_DEPTH.
//   An errored write leaves memory untouched; an errored read returns PRDATA=0.
//  PRDATA = mem[idx] during the PREADY cycle of a successful read, else 0.
//   A read of the word written by the immediately preceding transfer returns the new value.
//  Bus values are latched in SETUP. Changes to PADDR/PWDATA during ACCESS are ignored (sampled copy used).
//  Reset wins over everything, including a completing write, which is discarded.
// TESTING
//  1 Reset: PRESET=1 for 2 cycles -> PREADY=0, PSLVERR=0, PRDATA=0, xfer_cnt=0. Read idx 5 afterwards -> 0x00.
//  2 WAIT_CYCLES=2: write 0x5A to idx 3 -> PREADY low 2 access cycles, high on the 3rd.
//    Read idx 3 -> PRDATA=0x5A with PREADY; xfer_cnt=2.
//  3 Back-to-back: write idx 0..5 with data 2*i, no IDLE gaps, then read all six -> 0,2,4,6,8,10; xfer_cnt=12.
//  4 Error: write 0xFF to idx 50 -> PSLVERR=1 with PREADY. Read idx 50 -> PSLVERR=1, PRDATA=0.
//    Read idx 47 still returns its prior value.
//  5 Abort: drop PSELECT in ACCESS with wcnt=1 on a write of 0x11 to idx 7 -> no PREADY, idx 7 unchanged,
//    xfer_cnt unchanged.
//  6 Reset mid-access: PRESET=1 in ACCESS -> IDLE next cycle, write not committed, PREADY never asserted.
//    WAIT_CYCLES=0 rerun of test 2 -> PREADY in the first access cycle.

Source files
------------

// File: rtl/apb_wait_slave.sv
// apb_wait_slave
// APB completer backed by a small register file, with a fixed number of
// wait states in the access phase and an error response for words beyond
// the implemented depth. PREADY/PSLVERR/PRDATA are decoded from registered
// state only, so the bus inputs never reach them combinationally.
module apb_wait_slave #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int MEM_DEPTH   = 48,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSELECT,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [7:0]        xfer_cnt
);

    localparam int IDX_W = ADDR_W - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [IDX_W-1:0]    r_idx;
    logic                r_write;
    logic [DATA_W-1:0]   r_wdata;
    logic [7:0]          r_wcnt;
    logic [7:0]          r_xferCnt;
    logic [DATA_W-1:0]   r_mem [MEM_DEPTH];

    logic                w_latch;
    logic                w_wcntClr;
    logic                w_wcntInc;
    logic                w_complete;
    logic                w_ready;
    logic                w_err;
    logic [31:0]         w_idxWide;
    logic                w_unusedSelBit;

    // The address MSB selects this slave upstream; the slave itself ignores it.
    assign w_unusedSelBit = PADDR[ADDR_W-1];

    // Ready and error decoded purely from the latched copy of the transfer.
    assign w_idxWide = 32'(r_idx);
    assign w_err     = (w_idxWide >= 32'(MEM_DEPTH));
    assign w_ready   = (r_state == ACCESS) && (r_wcnt == 8'(WAIT_CYCLES));

    assign PREADY   = w_ready;
    assign PSLVERR  = w_ready && w_err;
    assign PRDATA   = (w_ready && !r_write && !w_err) ? r_mem[r_idx] : '0;
    assign xfer_cnt = r_xferCnt;

    // Next-state and datapath control for the IDLE/SETUP/ACCESS handshake.
    always_comb begin
        w_nextState = r_state;
        w_latch     = 1'b0;
        w_wcntClr   = 1'b0;
        w_wcntInc   = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            IDLE: begin
                if (PSELECT && !PENABLE) begin
                    w_nextState = SETUP;
                    w_latch     = 1'b1;
                end
            end
            SETUP: begin
                if (!PSELECT) begin
                    w_nextState = IDLE;
                end else if (PENABLE) begin
                    w_nextState = ACCESS;
                    w_wcntClr   = 1'b1;
                end else begin
                    w_latch = 1'b1;
                end
            end
            ACCESS: begin
                if (w_ready) begin
                    w_complete = 1'b1;
                    if (PSELECT && !PENABLE) begin
                        w_nextState = SETUP;
                        w_latch     = 1'b1;
                    end else begin
                        w_nextState = IDLE;
                    end
                end else if (PSELECT && PENABLE) begin
                    w_wcntInc = 1'b1;
                end else begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // State, latched bus copy, wait counter and transfer counter.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_write   <= 1'b0;
            r_wdata   <= '0;
            r_wcnt    <= '0;
            r_xferCnt <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_latch) begin
                r_idx   <= PADDR[IDX_W-1:0];
                r_write <= PWRITE;
                r_wdata <= PWDATA;
            end
            if (w_wcntClr) begin
                r_wcnt <= '0;
            end else if (w_wcntInc) begin
                r_wcnt <= r_wcnt + 8'd1;
            end
            if (w_complete) begin
                r_xferCnt <= r_xferCnt + 8'd1;
            end
        end
    end

    // Register file: cleared on reset, written only by a successful completing write.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_complete && r_write && !w_err) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

endmodule
